// File: rtl/numbo_pkg.sv
// Shared widths, digit limits and index helpers for the digit register bank and edit UI.
// Valid digit slots are 4k+0..4k+2; slot 4k+3 is a spacer that is never stored or scanned.
package numbo_pkg;

    localparam int DIGIT_W      = 4;
    localparam int IDX_W        = 5;
    localparam int NUM_IDX      = 32;
    localparam int GROUP_STRIDE = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return idx[1:0] != 2'b11;
    endfunction

    // 5-bit wrap carries 31 -> 0, so 30 -> 0 falls out of the same skip as 2 -> 4.
    function automatic logic [IDX_W-1:0] next_valid_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] n;
        n = idx + 1'b1;
        if (!idx_valid(n)) n = n + 1'b1;
        return n;
    endfunction

endpackage

// File: rtl/numbo_digit_regs_if.sv
// Edit-UI to digit-bank bundle: increment strobes, cursor, scan control and bank/scan readback.
// No backpressure; every signal is sampled or presented each clk.
interface numbo_digit_regs_if;
    import numbo_pkg::*;

    logic [NUM_IDX-1:0]         doInc;
    logic [IDX_W-1:0]           digit;
    logic                       blink;
    logic                       clearAll;
    logic                       scanAdv;
    logic [NUM_IDX*DIGIT_W-1:0] regs;
    logic [IDX_W-1:0]           scanIdx;
    logic [DIGIT_W-1:0]         scanVal;
    logic                       scanBlank;
    logic                       incAck;

    modport master (
        output doInc, digit, blink, clearAll, scanAdv,
        input  regs, scanIdx, scanVal, scanBlank, incAck
    );

    modport slave (
        input  doInc, digit, blink, clearAll, scanAdv,
        output regs, scanIdx, scanVal, scanBlank, incAck
    );

endinterface

// File: rtl/numbo_bcd_digit.sv
// Single BCD digit: wraps DIGIT_MAX -> 0 on inc, clr wins; 1-cycle update.
// nextValue exposes the post-write value so readers can be write-first.
module numbo_bcd_digit
    import numbo_pkg::*;
(
    input  logic               clk,
    input  logic               resetDigit,
    input  logic               inc,
    input  logic               clr,
    output logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] nextValue
);

    always_comb begin
        nextValue = value;
        if (clr) begin
            nextValue = '0;
        end else if (inc) begin
            // >= rather than == so a corrupted out-of-range value recovers to 0
            nextValue = (value >= DIGIT_MAX) ? '0 : DIGIT_W'(value + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge resetDigit) begin
        if (resetDigit) value <= '0;
        else            value <= nextValue;
    end

endmodule

// File: rtl/numbo_digit_regs.sv
// 24-digit BCD bank with rising-edge increments, sync clear and a 1-cycle registered display scan.
// No backpressure; incAck pulses the cycle after any accepted valid-index increment.
module numbo_digit_regs
    import numbo_pkg::*;
(
    input  logic             clk,
    input  logic             resetDigit,
    numbo_digit_regs_if.slave bus
);

    logic [NUM_IDX-1:0]         prevInc;
    logic [NUM_IDX-1:0]         rise;
    logic [NUM_IDX-1:0]         validMask;
    logic [NUM_IDX*DIGIT_W-1:0] bankQ;
    logic [NUM_IDX*DIGIT_W-1:0] bankD;
    logic [DIGIT_W-1:0]         scanNext;
    logic [IDX_W-1:0]           scanIdx;
    logic [DIGIT_W-1:0]         scanVal;
    logic                       scanBlank;
    logic                       incAck;

    assign rise = bus.doInc & ~prevInc;

    genvar i;
    generate
        for (i = 0; i < NUM_IDX; i++) begin : gDigit
            if (idx_valid(IDX_W'(i))) begin : gValid
                assign validMask[i] = 1'b1;
                numbo_bcd_digit uDigit (
                    .clk        (clk),
                    .resetDigit (resetDigit),
                    .inc        (rise[i]),
                    .clr        (bus.clearAll),
                    .value      (bankQ[i*DIGIT_W +: DIGIT_W]),
                    .nextValue  (bankD[i*DIGIT_W +: DIGIT_W])
                );
            end else begin : gUnused
                assign validMask[i]                = 1'b0;
                assign bankQ[i*DIGIT_W +: DIGIT_W] = '0;
                assign bankD[i*DIGIT_W +: DIGIT_W] = '0;
            end
        end
    endgenerate

    // Read the next-state bank so the display never shows a stale value after an edit
    assign scanNext = bankD[scanIdx*DIGIT_W +: DIGIT_W];

    always_ff @(posedge clk or posedge resetDigit) begin
        if (resetDigit) begin
            prevInc   <= '1;
            incAck    <= 1'b0;
            scanIdx   <= '0;
            scanVal   <= '0;
            scanBlank <= 1'b0;
        end else begin
            prevInc   <= bus.doInc;
            incAck    <= ~bus.clearAll & (|(rise & validMask));
            if (bus.scanAdv) scanIdx <= next_valid_idx(scanIdx);
            scanVal   <= scanNext;
            scanBlank <= bus.blink & (scanIdx == bus.digit);
        end
    end

    assign bus.regs      = bankQ;
    assign bus.scanIdx   = scanIdx;
    assign bus.scanVal   = scanVal;
    assign bus.scanBlank = scanBlank;
    assign bus.incAck    = incAck;

endmodule
